// File: rtl/str_stream_sched_if.sv
// Bundle between the string scheduler and its requesters/text sink.
// The master modport is the requester/sink side; the slave modport is the scheduler.
interface str_stream_sched_if #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned MAXCH = 80,
  parameter int unsigned LENW  = 7
);
  logic [NREQ-1:0]         req;
  logic [NREQ*8*MAXCH-1:0] str_data;
  logic [NREQ*LENW-1:0]    str_len;
  logic [NREQ-1:0]         ack;
  logic [7:0]              out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;
  logic                    busy;

  modport master (
    output req, str_data, str_len, out_ready,
    input  ack, out_data, out_valid, out_last, busy
  );

  modport slave (
    input  req, str_data, str_len, out_ready,
    output ack, out_data, out_valid, out_last, busy
  );
endinterface

// File: rtl/str_stream_sched.sv
// Round-robin scheduler that snapshots one requester's packed string and streams
// it one character per valid/ready beat onto a shared 8-bit channel.
module str_stream_sched #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned MAXCH = 80,
  parameter int unsigned LENW  = 7
) (
  input logic              clk,
  input logic              rst,
  str_stream_sched_if.slave bus
);
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned SW = 8 * MAXCH;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StSend = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   last_grant_q, last_grant_d;
  logic [IW-1:0]   winner_q, winner_d;
  logic [SW-1:0]   snap_q, snap_d;
  logic [LENW-1:0] len_q, len_d;
  logic [LENW-1:0] idx_q, idx_d;

  logic [IW-1:0]   pick;
  logic            pick_vld;
  logic [LENW-1:0] raw_len, clamp_len;
  logic [SW-1:0]   raw_str;
  logic [31:0]     shamt;
  logic            beat_fire, is_last;

  // First requester found walking cyclically from the one after the last grant.
  always_comb begin : arb
    int unsigned k;
    k        = 0;
    pick     = last_grant_q;
    pick_vld = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      k = (32'(last_grant_q) + i) % NREQ;
      if (!pick_vld && bus.req[k]) begin
        pick     = IW'(k);
        pick_vld = 1'b1;
      end
    end
  end

  assign raw_len   = bus.str_len[winner_q*LENW +: LENW];
  assign clamp_len = (raw_len > LENW'(MAXCH)) ? LENW'(MAXCH) : raw_len;
  assign raw_str   = bus.str_data[winner_q*SW +: SW];
  // Left-justify so the first character always sits in the top byte of the snapshot.
  assign shamt     = 32'(8) * (32'(MAXCH) - 32'(clamp_len));

  assign beat_fire = (state_q == StSend) && bus.out_ready;
  assign is_last   = (idx_q == len_q - LENW'(1));

  always_comb begin : next_state
    state_d      = state_q;
    last_grant_d = last_grant_q;
    winner_d     = winner_q;
    snap_d       = snap_q;
    len_d        = len_q;
    idx_d        = idx_q;
    case (state_q)
      StIdle: begin
        if (pick_vld) begin
          winner_d = pick;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        snap_d       = raw_str << shamt;
        len_d        = clamp_len;
        idx_d        = '0;
        last_grant_d = winner_q;
        state_d      = (clamp_len == '0) ? StIdle : StSend;
      end
      StSend: begin
        if (beat_fire) begin
          if (is_last) begin
            state_d = StIdle;
          end else begin
            idx_d  = idx_q + LENW'(1);
            snap_d = snap_q << 8;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= IW'(NREQ - 1);
      winner_q     <= '0;
      snap_q       <= '0;
      len_q        <= '0;
      idx_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      winner_q     <= winner_d;
      snap_q       <= snap_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
    end
  end

  always_comb begin : ack_dec
    bus.ack = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      bus.ack[k] = (state_q == StLoad) && (winner_q == IW'(k));
    end
  end

  assign bus.out_valid = (state_q == StSend);
  assign bus.out_data  = (state_q == StSend) ? snap_q[SW-1 -: 8] : 8'h00;
  assign bus.out_last  = (state_q == StSend) && is_last;
  assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_str_stream_sched.sv
// Randomized scoreboard bench for str_stream_sched: a queue-based reference model
// predicts grant order and character stream; a negedge monitor compares DUT output.
module tb_str_stream_sched;
  localparam int unsigned NREQ  = 2;
  localparam int unsigned MAXCH = 80;
  localparam int unsigned LENW  = 7;
  localparam int unsigned SW    = 8 * MAXCH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  str_stream_sched_if #(.NREQ(NREQ), .MAXCH(MAXCH), .LENW(LENW)) bus ();

  str_stream_sched #(.NREQ(NREQ), .MAXCH(MAXCH), .LENW(LENW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  int         exp_ack[$];
  int         exp_len[$];
  logic [8:0] exp_beat[$];   // {last, char}
  int         m_last;

  logic [SW-1:0] b_str [NREQ];
  int            b_len [NREQ];
  int            b_hold[NREQ];

  bit         mon_en = 1'b0;
  bit         pend_ack = 1'b0;
  int         pend_len = 0;
  bit         pend_idle = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic rdy(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return ($urandom_range(0, 3) != 0);
      default: return !(c >= 3 && c <= 5);
    endcase
  endfunction

  // Reference model: grants go to the next requester (cyclically after the last
  // grant) that still has outstanding requests; each grant emits its clamped string.
  task automatic predict();
    int            cnt[NREQ];
    int            win, k, len_c;
    bit            any;
    logic [SW-1:0] s;
    for (int i = 0; i < NREQ; i++) cnt[i] = b_hold[i];
    any = 1'b1;
    while (any) begin
      win = -1;
      for (int i = 1; i <= NREQ; i++) begin
        k = (m_last + i) % NREQ;
        if (win < 0 && cnt[k] > 0) win = k;
      end
      if (win < 0) begin
        any = 1'b0;
      end else begin
        len_c = (b_len[win] > MAXCH) ? MAXCH : b_len[win];
        exp_ack.push_back(win);
        exp_len.push_back(len_c);
        s = b_str[win];
        for (int j = 0; j < len_c; j++) begin
          exp_beat.push_back({(j == len_c - 1), s[8*(len_c-1-j) +: 8]});
        end
        cnt[win]--;
        m_last = win;
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (pend_ack) begin
        chk("valid_after_ack", bus.out_valid, (pend_len > 0));
        if (pend_len == 0) chk("busy_after_empty", bus.busy, 0);
        pend_ack = 1'b0;
      end
      if (pend_idle) begin
        chk("idle_after_last", {bus.busy, bus.out_valid}, 0);
        pend_idle = 1'b0;
      end
      if (prev_stall) begin
        chk("stall_hold", {bus.out_valid, bus.out_last, bus.out_data},
            {1'b1, prev_last, prev_data});
      end
      if (|bus.ack) begin
        if (exp_ack.size() == 0) begin
          chk("unexpected_ack", bus.ack, 0);
        end else begin
          chk("ack_grant", bus.ack, 64'(1) << exp_ack.pop_front());
          pend_len = exp_len.pop_front();
          pend_ack = 1'b1;
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_beat.size() == 0) begin
          chk("unexpected_beat", {bus.out_last, bus.out_data}, 0);
        end else begin
          chk("beat", {bus.out_last, bus.out_data}, exp_beat.pop_front());
          if (bus.out_last) pend_idle = 1'b1;
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
    end
  end

  task automatic clear_sb();
    exp_ack.delete();
    exp_len.delete();
    exp_beat.delete();
    pend_ack   = 1'b0;
    pend_idle  = 1'b0;
    prev_stall = 1'b0;
    m_last     = NREQ - 1;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst = 1'b1;
    bus.req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_sb();
    mon_en = 1'b1;
  endtask

  task automatic load_inputs();
    for (int k = 0; k < NREQ; k++) begin
      bus.str_data[k*SW +: SW]     = b_str[k];
      bus.str_len[k*LENW +: LENW]  = LENW'(b_len[k]);
    end
  endtask

  // Entered #1 after a posedge with the DUT idle; that cycle is cycle 0.
  task automatic run_batch(input int mode, input bit check_lat);
    int               rem[NREQ];
    logic [NREQ-1:0]  rq, drop;
    int               cyc, first_ack;
    bit               done, all_zero;
    predict();
    load_inputs();
    for (int k = 0; k < NREQ; k++) begin
      rem[k] = b_hold[k];
      rq[k]  = (b_hold[k] > 0);
    end
    bus.req       = rq;
    bus.out_ready = rdy(mode, 0);
    cyc = 0;
    first_ack = -1;
    done = 1'b0;
    while (!done && cyc < 4000) begin
      @(negedge clk);
      drop = '0;
      for (int k = 0; k < NREQ; k++) begin
        if (bus.ack[k]) begin
          if (first_ack < 0) first_ack = cyc;
          rem[k]--;
          if (rem[k] <= 0) drop[k] = 1'b1;
        end
      end
      all_zero = 1'b1;
      for (int k = 0; k < NREQ; k++) if (rem[k] > 0) all_zero = 1'b0;
      done = all_zero && !bus.busy;
      @(posedge clk);
      #1;
      rq = rq & ~drop;
      bus.req = rq;
      cyc++;
      bus.out_ready = rdy(mode, cyc);
    end
    if (!done) chk("batch_timeout", 0, 1);
    if (check_lat) chk("ack_latency", 64'(first_ack), 1);
    repeat (2) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    chk("leftover_beats", 64'(exp_beat.size()), 0);
    chk("leftover_acks", 64'(exp_ack.size()), 0);
  endtask

  task automatic rand_str(input int k);
    for (int w = 0; w < SW / 32; w++) b_str[k][w*32 +: 32] = $urandom();
  endtask

  task automatic clear_batch();
    for (int k = 0; k < NREQ; k++) begin
      b_str[k]  = '0;
      b_len[k]  = 0;
      b_hold[k] = 0;
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.req       = '0;
    bus.str_data  = '0;
    bus.str_len   = '0;
    bus.out_ready = 1'b1;
    clear_sb();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 8'h00);
    chk("rst_last", bus.out_last, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ack", bus.ack, 0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // "hello" from requester 0, always-ready sink
    clear_batch();
    b_str[0][39:0] = "hello";
    b_len[0] = 5;
    b_hold[0] = 1;
    run_batch(0, 1'b1);

    // Both requesting, req0 held for two grants: order 0, 1, 0
    do_reset();
    clear_batch();
    rand_str(0);
    rand_str(1);
    b_len[0] = 2;  b_len[1] = 3;
    b_hold[0] = 2; b_hold[1] = 1;
    run_batch(0, 1'b1);

    // "abc" with the sink stalling 3 cycles on 'b'
    clear_batch();
    b_str[0][23:0] = "abc";
    b_len[0] = 3;
    b_hold[0] = 1;
    run_batch(2, 1'b1);

    // Zero-length string
    clear_batch();
    rand_str(0);
    b_len[0] = 0;
    b_hold[0] = 1;
    run_batch(0, 1'b1);

    // Over-long length clamps to MAXCH
    clear_batch();
    rand_str(0);
    b_len[0] = 100;
    b_hold[0] = 1;
    run_batch(0, 1'b1);

    // Reset during the 3rd beat of a 10-character string
    clear_batch();
    rand_str(0);
    b_len[0] = 10;
    b_hold[0] = 1;
    predict();
    load_inputs();
    bus.req = 2'b01;
    bus.out_ready = 1'b1;
    @(posedge clk); #1 bus.req = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    mon_en = 1'b0;
    clear_sb();
    @(negedge clk);
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_last", bus.out_last, 0);
    mon_en = 1'b1;
    @(posedge clk); #1;
    clear_batch();
    rand_str(0);
    rand_str(1);
    b_len[0] = 4;  b_len[1] = 6;
    b_hold[0] = 1; b_hold[1] = 1;
    run_batch(1, 1'b1);

    // Randomized mix of masks, lengths, holds and sink back-pressure
    for (int t = 0; t < 25; t++) begin
      clear_batch();
      for (int k = 0; k < NREQ; k++) begin
        rand_str(k);
        b_len[k]  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 100)
                                                 : $urandom_range(0, 12);
        b_hold[k] = $urandom_range(0, 2);
      end
      if (b_hold[0] == 0 && b_hold[1] == 0) b_hold[$urandom_range(0, NREQ - 1)] = 1;
      run_batch($urandom_range(0, 1), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
